// File: rtl/ad9252_ctrl_pkg.sv
// Shared types and constants for the AD9252 init sequencer.
// State codes double as the ctrl_fsm debug encoding.
package ad9252_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_RST   = 4'd1,
        ST_SETTLE1  = 4'd2,
        ST_WR_TEST  = 4'd3,
        ST_WR_XFER1 = 4'd4,
        ST_SETTLE2  = 4'd5,
        ST_ALIGN    = 4'd6,
        ST_WR_NORM  = 4'd7,
        ST_WR_XFER2 = 4'd8,
        ST_RUN      = 4'd9,
        ST_RETRY    = 4'd10,
        ST_FAIL     = 4'd11
    } ctrl_state_e;

    localparam logic [12:0] ADDR_CHIP_PORT = 13'h000;
    localparam logic [12:0] ADDR_TEST_IO   = 13'h00D;
    localparam logic [12:0] ADDR_XFER      = 13'h0FF;

    localparam logic [7:0] SOFT_RST_VAL = 8'h3C;
    localparam logic [7:0] XFER_VAL     = 8'h01;
    localparam logic [7:0] NORMAL_VAL   = 8'h00;

    // Consecutive synchronised lock cycles needed to accept alignment.
    localparam int ALIGN_HITS = 4;

    typedef struct packed {
        logic [12:0] addr;
        logic [7:0]  data;
    } spi_wr_t;

    function automatic spi_wr_t wr_cmd(input logic [12:0] addr,
                                       input logic [7:0]  data);
        spi_wr_t c;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/ad9252_init_ctrl_spi_wr_req.sv
// Single-outstanding SPI write requester: latches addr/data on start,
// holds req until ack, then emits a one-cycle done pulse.
module spi_wr_req (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [12:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        spi_ack_i,
    output logic        spi_req_o,
    output logic [12:0] spi_addr_o,
    output logic [7:0]  spi_wdata_o,
    output logic        done_o
);

    logic        req_q, req_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;

    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        data_d = data_q;
        done_d = 1'b0;
        if (req_q) begin
            if (spi_ack_i) begin
                req_d  = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            req_d  = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            req_q  <= req_d;
            addr_q <= addr_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end

    assign spi_req_o   = req_q;
    assign spi_addr_o  = addr_q;
    assign spi_wdata_o = data_q;
    assign done_o      = done_q;

endmodule

// File: rtl/ad9252_init_ctrl.sv
// AD9252 power-up / recovery sequencer: SPI programming, wrapper
// reset/start control, alignment wait with retry and lock-loss recovery.
module ad9252_init_ctrl
    import ad9252_ctrl_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         ALIGN_TIMEOUT = 2000000,
    parameter int         MAX_RETRY     = 3,
    parameter logic [7:0] TEST_PATTERN  = 8'h04,
    parameter int         RST_PULSE     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        spi_req,
    output logic [12:0] spi_addr,
    output logic [7:0]  spi_wdata,
    input  logic        spi_ack,
    input  logic        dco_done,
    input  logic        data_aligned,
    output logic        ad_spi_done,
    output logic        ad_test_mode,
    output logic        soft_rst,
    output logic        soft_start,
    output logic        init_done,
    output logic        init_fail,
    output logic [3:0]  retry_cnt,
    output logic [3:0]  ctrl_fsm
);

    localparam int TW = $clog2(ALIGN_TIMEOUT) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int PW = $clog2(RST_PULSE) + 1;

    localparam logic [TW-1:0] TIMER_LAST  = TW'(ALIGN_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(RST_PULSE - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [2:0]    HIT_LAST    = 3'(ALIGN_HITS - 1);

    ctrl_state_e   state_q;
    logic          dco_meta_q, dco_sync_q;
    logic          aln_meta_q, aln_sync_q;
    logic [SW-1:0] settle_q;
    logic [TW-1:0] timer_q;
    logic [PW-1:0] pulse_q;
    logic [2:0]    hit_q;
    logic [3:0]    retry_q;
    logic          wr_start_q;
    spi_wr_t       wr_cmd_q;
    logic          spi_done_q, test_mode_q, soft_rst_q;
    logic          soft_start_q, init_done_q, init_fail_q;
    logic          wr_done;
    logic          lock_ok;
    logic          align_hit;

    assign lock_ok   = dco_sync_q & aln_sync_q;
    assign align_hit = lock_ok && (hit_q == HIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dco_meta_q <= 1'b0;
            dco_sync_q <= 1'b0;
            aln_meta_q <= 1'b0;
            aln_sync_q <= 1'b0;
        end else begin
            dco_meta_q <= dco_done;
            dco_sync_q <= dco_meta_q;
            aln_meta_q <= data_aligned;
            aln_sync_q <= aln_meta_q;
        end
    end

    spi_wr_req u_spi_wr (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (wr_start_q),
        .addr_i      (wr_cmd_q.addr),
        .data_i      (wr_cmd_q.data),
        .spi_ack_i   (spi_ack),
        .spi_req_o   (spi_req),
        .spi_addr_o  (spi_addr),
        .spi_wdata_o (spi_wdata),
        .done_o      (wr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            timer_q      <= '0;
            pulse_q      <= '0;
            hit_q        <= '0;
            retry_q      <= '0;
            wr_start_q   <= 1'b0;
            wr_cmd_q     <= '0;
            spi_done_q   <= 1'b0;
            test_mode_q  <= 1'b0;
            soft_rst_q   <= 1'b1;
            soft_start_q <= 1'b0;
            init_done_q  <= 1'b0;
            init_fail_q  <= 1'b0;
        end else begin
            wr_start_q   <= 1'b0;
            soft_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    soft_rst_q <= 1'b1;
                    if (start) begin
                        state_q    <= ST_WR_RST;
                        wr_start_q <= 1'b1;
                        wr_cmd_q   <= wr_cmd(ADDR_CHIP_PORT, SOFT_RST_VAL);
                    end
                end
                ST_WR_RST: begin
                    if (wr_done) begin
                        state_q  <= ST_SETTLE1;
                        settle_q <= '0;
                    end
                end
                ST_SETTLE1: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q    <= ST_WR_TEST;
                        wr_start_q <= 1'b1;
                        wr_cmd_q   <= wr_cmd(ADDR_TEST_IO, TEST_PATTERN);
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_WR_TEST: begin
                    if (wr_done) begin
                        state_q    <= ST_WR_XFER1;
                        wr_start_q <= 1'b1;
                        wr_cmd_q   <= wr_cmd(ADDR_XFER, XFER_VAL);
                    end
                end
                ST_WR_XFER1: begin
                    if (wr_done) begin
                        state_q  <= ST_SETTLE2;
                        settle_q <= '0;
                    end
                end
                ST_SETTLE2: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q      <= ST_ALIGN;
                        spi_done_q   <= 1'b1;
                        test_mode_q  <= 1'b1;
                        soft_rst_q   <= 1'b0;
                        soft_start_q <= 1'b1;
                        timer_q      <= '0;
                        hit_q        <= '0;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_ALIGN: begin
                    timer_q <= timer_q + TW'(1);
                    hit_q   <= lock_ok ? hit_q + 3'd1 : 3'd0;
                    // Alignment is checked first so it beats a same-cycle timeout.
                    if (align_hit) begin
                        state_q    <= ST_WR_NORM;
                        wr_start_q <= 1'b1;
                        wr_cmd_q   <= wr_cmd(ADDR_TEST_IO, NORMAL_VAL);
                    end else if (timer_q == TIMER_LAST) begin
                        state_q     <= ST_RETRY;
                        spi_done_q  <= 1'b0;
                        test_mode_q <= 1'b0;
                        soft_rst_q  <= 1'b1;
                        pulse_q     <= '0;
                        retry_q     <= sat_inc4(retry_q);
                    end
                end
                ST_WR_NORM: begin
                    if (wr_done) begin
                        state_q    <= ST_WR_XFER2;
                        wr_start_q <= 1'b1;
                        wr_cmd_q   <= wr_cmd(ADDR_XFER, XFER_VAL);
                    end
                end
                ST_WR_XFER2: begin
                    if (wr_done) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                        test_mode_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Lock loss or a host restart re-initialises from a fresh count.
                    if (!dco_sync_q || start) begin
                        state_q     <= ST_RETRY;
                        init_done_q <= 1'b0;
                        spi_done_q  <= 1'b0;
                        test_mode_q <= 1'b0;
                        soft_rst_q  <= 1'b1;
                        pulse_q     <= '0;
                        retry_q     <= 4'd1;
                    end
                end
                ST_RETRY: begin
                    if (pulse_q == PULSE_LAST) begin
                        if (retry_q >= RETRY_LIMIT) begin
                            state_q     <= ST_FAIL;
                            init_fail_q <= 1'b1;
                        end else begin
                            state_q    <= ST_WR_RST;
                            soft_rst_q <= 1'b0;
                            wr_start_q <= 1'b1;
                            wr_cmd_q   <= wr_cmd(ADDR_CHIP_PORT, SOFT_RST_VAL);
                        end
                    end else begin
                        pulse_q <= pulse_q + PW'(1);
                    end
                end
                ST_FAIL: begin
                    soft_rst_q <= 1'b1;
                    if (start) begin
                        state_q     <= ST_WR_RST;
                        init_fail_q <= 1'b0;
                        retry_q     <= '0;
                        wr_start_q  <= 1'b1;
                        wr_cmd_q    <= wr_cmd(ADDR_CHIP_PORT, SOFT_RST_VAL);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ad_spi_done  = spi_done_q;
    assign ad_test_mode = test_mode_q;
    assign soft_rst     = soft_rst_q;
    assign soft_start   = soft_start_q;
    assign init_done    = init_done_q;
    assign init_fail    = init_fail_q;
    assign retry_cnt    = retry_q;
    assign ctrl_fsm     = state_q;

endmodule

// File: tb/tb_ad9252_init_ctrl.sv
// Scoreboarded bench for ad9252_init_ctrl: an SPI slave monitor checks
// writes against an expected queue filled by the stimulus flow.
module tb_ad9252_init_ctrl;

    localparam int         SETTLE = 20;
    localparam int         ALIGN_TO = 200;
    localparam int         MAXR = 3;
    localparam logic [7:0] TPAT = 8'h04;
    localparam int         RSTW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        spi_req;
    logic [12:0] spi_addr;
    logic [7:0]  spi_wdata;
    logic        ack_m = 1'b0;
    logic        ack_tb = 1'b0;
    logic        spi_ack;
    logic        dco_done = 1'b0;
    logic        data_aligned = 1'b0;
    logic        ad_spi_done, ad_test_mode, soft_rst, soft_start;
    logic        init_done, init_fail;
    logic [3:0]  retry_cnt, ctrl_fsm;

    int total = 0;
    int bad = 0;
    logic [20:0] exp_q[$];
    bit ack_fixed = 1'b1;
    bit no_ack = 1'b0;

    assign spi_ack = ack_m | ack_tb;

    always #5 clk = ~clk;

    ad9252_init_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .ALIGN_TIMEOUT (ALIGN_TO),
        .MAX_RETRY     (MAXR),
        .TEST_PATTERN  (TPAT),
        .RST_PULSE     (RSTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .spi_req      (spi_req),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_ack      (spi_ack),
        .dco_done     (dco_done),
        .data_aligned (data_aligned),
        .ad_spi_done  (ad_spi_done),
        .ad_test_mode (ad_test_mode),
        .soft_rst     (soft_rst),
        .soft_start   (soft_start),
        .init_done    (init_done),
        .init_fail    (init_fail),
        .retry_cnt    (retry_cnt),
        .ctrl_fsm     (ctrl_fsm)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference write programs: bring-up writes and switch-to-normal writes.
    task automatic push_init();
        exp_q.push_back({13'h000, 8'h3C});
        exp_q.push_back({13'h00D, TPAT});
        exp_q.push_back({13'h0FF, 8'h01});
    endtask

    task automatic push_norm();
        exp_q.push_back({13'h00D, 8'h00});
        exp_q.push_back({13'h0FF, 8'h01});
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget,
                              input string nm);
        int n = 0;
        while (ctrl_fsm !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(ctrl_fsm), 32'(s));
    endtask

    // SPI slave + scoreboard monitor.
    initial begin : spi_mon
        logic [20:0] got;
        logic [20:0] exp;
        int dly;
        int n;
        forever begin
            @(negedge clk);
            if (spi_req === 1'b1) begin
                got = {spi_addr, spi_wdata};
                if (exp_q.size() == 0) begin
                    chk("spi_unexpected", 32'(got), 32'h1FFFFF);
                end else begin
                    exp = exp_q.pop_front();
                    chk("spi_write", 32'(got), 32'(exp));
                end
                dly = ack_fixed ? 5 : int'($urandom_range(1, 6));
                n = 1;
                while (spi_req && (n < dly || no_ack) && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                if (spi_req) begin
                    chk("spi_hold", 32'({spi_addr, spi_wdata}), 32'(got));
                    ack_m = 1'b1;
                    @(negedge clk);
                    ack_m = 1'b0;
                    chk("spi_req_drop", 32'(spi_req), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int w;
        int glen;
        int rises;
        int acnt;
        logic prev;
        logic [3:0] prev_st;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fsm", 32'(ctrl_fsm), 0);
        chk("rst_soft_rst", 32'(soft_rst), 1);
        chk("rst_req", 32'(spi_req), 0);
        chk("rst_done", 32'(init_done), 0);
        chk("rst_fail", 32'(init_fail), 0);
        chk("rst_retry", 32'(retry_cnt), 0);
        chk("rst_spi_done", 32'(ad_spi_done), 0);
        chk("rst_test", 32'(ad_test_mode), 0);
        chk("rst_sstart", 32'(soft_start), 0);

        // Normal bring-up with glitch and ignored starts
        rst_n = 1'b1;
        ack_fixed = 1'b1;
        push_init();
        push_norm();
        pulse_start();
        chk("t1_wr_rst", 32'(ctrl_fsm), 1);
        wait_state(4'd2, 100, "t1_settle1");
        pulse_start();
        chk("t1_start_settle", 32'(ctrl_fsm), 2);
        wait_state(4'd6, 300, "t1_align");
        chk("t1_sstart_hi", 32'(soft_start), 1);
        chk("t1_spi_done", 32'(ad_spi_done), 1);
        chk("t1_test_mode", 32'(ad_test_mode), 1);
        chk("t1_soft_rst", 32'(soft_rst), 0);
        @(negedge clk);
        chk("t1_sstart_lo", 32'(soft_start), 0);
        repeat (8) @(negedge clk);
        dco_done = 1'b1;
        pulse_start();
        chk("t1_start_align", 32'(ctrl_fsm), 6);
        repeat (20) @(negedge clk);
        glen = int'($urandom_range(1, 3));
        data_aligned = 1'b1;
        repeat (glen) @(negedge clk);
        data_aligned = 1'b0;
        repeat (10) @(negedge clk);
        chk("t1_glitch", 32'(ctrl_fsm), 6);
        repeat (60) @(negedge clk);
        data_aligned = 1'b1;
        n = 0;
        while (ctrl_fsm !== 4'd7 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_align_lat", 32'(n), 2 + 4);
        wait_state(4'd9, 200, "t1_run");
        chk("t1_init_done", 32'(init_done), 1);
        chk("t1_test_off", 32'(ad_test_mode), 0);
        chk("t1_spi_done_run", 32'(ad_spi_done), 1);
        chk("t1_retry", 32'(retry_cnt), 0);
        chk("t1_writes_left", 32'(exp_q.size()), 0);

        // Lock loss in RUN
        ack_fixed = 1'b0;
        push_init();
        push_norm();
        dco_done = 1'b0;
        n = 0;
        while (init_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t2_drop_lat", 32'(n), 3);
        chk("t2_retry_st", 32'(ctrl_fsm), 10);
        chk("t2_retry_cnt", 32'(retry_cnt), 1);
        chk("t2_spi_done", 32'(ad_spi_done), 0);
        w = 0;
        while (soft_rst && w < 50) begin
            w++;
            @(negedge clk);
        end
        chk("t2_pulse_w", 32'(w), RSTW);
        dco_done = 1'b1;
        wait_state(4'd9, 800, "t2_run");
        chk("t2_init_done", 32'(init_done), 1);
        chk("t2_retry_run", 32'(retry_cnt), 1);
        chk("t2_writes_left", 32'(exp_q.size()), 0);

        // Start while running forces re-initialisation
        pulse_start();
        chk("t2_start_run", 32'(ctrl_fsm), 10);
        chk("t2_start_done", 32'(init_done), 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Alignment never arrives: retries then FAIL
        dco_done = 1'b0;
        data_aligned = 1'b0;
        push_init();
        push_init();
        push_init();
        pulse_start();
        prev = soft_rst;
        prev_st = ctrl_fsm;
        rises = 0;
        w = 0;
        acnt = 0;
        n = 0;
        while (ctrl_fsm !== 4'd11 && n < 3000) begin
            @(negedge clk);
            n++;
            if (soft_rst && !prev) begin
                rises++;
                w = 1;
            end else if (soft_rst && prev) begin
                w++;
            end else if (!soft_rst && prev && rises > 0) begin
                chk("t3_pulse_w", 32'(w), RSTW);
            end
            if (ctrl_fsm == 4'd6) begin
                acnt++;
            end else if (prev_st == 4'd6) begin
                chk("t3_align_len", 32'(acnt), ALIGN_TO);
                acnt = 0;
            end
            prev = soft_rst;
            prev_st = ctrl_fsm;
        end
        chk("t3_fail_st", 32'(ctrl_fsm), 11);
        chk("t3_rises", 32'(rises), MAXR);
        chk("t3_init_fail", 32'(init_fail), 1);
        chk("t3_retry_cnt", 32'(retry_cnt), MAXR);
        chk("t3_soft_rst", 32'(soft_rst), 1);
        chk("t3_writes_left", 32'(exp_q.size()), 0);

        // Start in FAIL restarts; then reset mid-write
        no_ack = 1'b1;
        exp_q.push_back({13'h000, 8'h3C});
        pulse_start();
        chk("t3_restart_st", 32'(ctrl_fsm), 1);
        chk("t3_restart_fail", 32'(init_fail), 0);
        chk("t3_restart_retry", 32'(retry_cnt), 0);
        n = 0;
        while (!spi_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_req_up", 32'(spi_req), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_req_off", 32'(spi_req), 0);
        chk("t4_soft_rst", 32'(soft_rst), 1);
        chk("t4_idle", 32'(ctrl_fsm), 0);
        rst_n = 1'b1;
        @(negedge clk);
        no_ack = 1'b0;
        @(negedge clk);
        ack_tb = 1'b1;
        @(negedge clk);
        ack_tb = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_late_ack_req", 32'(spi_req), 0);
        chk("t4_late_ack_st", 32'(ctrl_fsm), 0);
        chk("t4_writes_left", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
